// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [WIDTH:0] mul_sum, div_top, div_trial;
  logic is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
  logic signed_op, go;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
  always_comb begin
    signed_op = md_op == 3'd1 || md_op == 3'd3;
    go = start && !cancel;
    abs_a = signed_op && src_a[WIDTH-1] ? -src_a : src_a;
    abs_b = signed_op && src_b[WIDTH-1] ? -src_b : src_b;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // acc holds {partial remainder, dividend bits not yet consumed / quotient bits}
    div_top = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_top - {1'b0, b_q};
    prod = neg_lo_q ? -acc_q : acc_q;
    quo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (go && md_op >= 3'd1 && md_op <= 3'd4) begin
        state_d = CALC;
        cnt_d = CW'(WIDTH);
        is_div_d = md_op >= 3'd3;
        neg_lo_d = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_hi_d = signed_op && src_a[WIDTH-1];
        a_d = src_a;
        b_d = abs_b;
        acc_d = {{WIDTH{1'b0}}, abs_a};
      end
      hi_d = go && md_op == 3'd5 ? src_a : hi_q;
      lo_d = go && md_op == 3'd6 ? src_a : lo_q;
    end else if (cancel) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? FIX : CALC;
      acc_d = is_div_q ? {div_trial[WIDTH] ? div_top[WIDTH-1:0] : div_trial[WIDTH-1:0],
                          acc_q[WIDTH-2:0], !div_trial[WIDTH]}
                       : {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      state_d = IDLE;
      done_d = 1'b1;
      // divide by zero returns the raw dividend in HI and all ones in LO
      hi_d = is_div_q ? (b_q == '0 ? a_q : rem) : prod[2*WIDTH-1:WIDTH];
      lo_d = is_div_q ? (b_q == '0 ? '1 : quo) : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with an arithmetic reference model
module tb_mul_div_unit;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0, cancel = 0;
  logic [2:0] md_op = 0;
  logic [W-1:0] src_a = 0, src_b = 0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  int errors = 0, checks = 0;
  logic [63:0] exp_q[$];
  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: return b == 0 ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: return b == 0 ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("spurious_done", {63'b0, done}, 64'd0);
      else chk("result_hi_lo", {hi, lo}, exp_q.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    start = 1; md_op = op; src_a = a;
    step();
    start = 0; md_op = 0;
    @(negedge clk);
    chk(op == 3'd5 ? "mthi" : "mtlo", {32'b0, op == 3'd5 ? hi : lo}, {32'b0, a});
    chk("mt_busy", {63'b0, busy}, 64'd0);
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(op, a, b));
    start = 1; md_op = op; src_a = a; src_b = b;
    step();
    start = 0; md_op = 0;
  endtask
  task automatic wait_done(input int exp_busy);
    int nb = 0;
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", {63'b0, got}, 64'd1);
    if (exp_busy >= 0) chk("busy_cycles", 64'(nb), 64'(exp_busy));
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_done(W + 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    rst = 1;
    repeat (2) step();
    @(negedge clk);
    chk("reset_hi_lo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
    rst = 0;
    step();
    mt(3'd5, 32'hDEADBEEF);
    mt(3'd6, 32'h12345678);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd1, -32'sd3, 32'd7);
    run_op(3'd3, -32'sd7, 32'd2);
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd4, 32'h55, 32'd0);
    run_op(3'd3, -32'sd5, 32'd0);
    // cancel mid-CALC leaves HI/LO untouched
    mt(3'd5, 32'hA);
    mt(3'd6, 32'hB);
    start = 1; md_op = 3'd2; src_a = 3; src_b = 4;
    step();
    start = 0; md_op = 0;
    repeat (9) step();
    cancel = 1;
    step();
    cancel = 0;
    @(negedge clk);
    chk("cancel_busy", {63'b0, busy}, 64'd0);
    chk("cancel_hi_lo", {hi, lo}, {32'hA, 32'hB});
    repeat (40) step();
    chk("cancel_hi_lo_late", {hi, lo}, {32'hA, 32'hB});
    // cancel in IDLE suppresses a same-cycle MTHI
    start = 1; md_op = 3'd5; src_a = 32'h999; cancel = 1;
    step();
    start = 0; md_op = 0; cancel = 0;
    @(negedge clk);
    chk("idle_cancel_mthi", {32'b0, hi}, 64'hA);
    // starts during busy are ignored
    issue(3'd2, 3, 4);
    repeat (5) step();
    start = 1; md_op = 3'd6; src_a = 32'hFFFF;
    step();
    start = 0; md_op = 0;
    @(negedge clk);
    chk("busy_mtlo_ignored", {32'b0, lo}, 64'hB);
    chk("busy_still", {63'b0, busy}, 64'd1);
    start = 1; md_op = 3'd2; src_a = 7; src_b = 7;
    step();
    start = 0; md_op = 0;
    wait_done(-1);
    repeat (40) step();
    // reset while in FIX
    mt(3'd5, 32'h1111);
    mt(3'd6, 32'h2222);
    start = 1; md_op = 3'd2; src_a = 5; src_b = 6;
    step();
    start = 0; md_op = 0;
    repeat (32) step();
    chk("in_fix_busy", {63'b0, busy}, 64'd1);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_fix_hi_lo", {hi, lo}, 64'd0);
    chk("rst_fix_busy_done", {62'b0, busy, done}, 64'd0);
    repeat (5) step();
    // back-to-back: second start on the done cycle
    run_op(3'd4, 9, 2);
    run_op(3'd2, 5, 6);
    for (int i = 0; i < 25; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom_range(0, 4) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(op, a, b);
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 0 ? 3'd5 : 3'd6, $urandom);
    end
    repeat (5) step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
